// File: rtl/decode_pkg.sv
// Shared types and constants for the instruction decode stage.
//   - Opcode constants for the supported instruction classes.
//   - imm_src_t : immediate-type select sent to the immediate extender.
//   - dec_t     : one fully decoded instruction as held in the output and
//                 skid registers.
package decode_pkg;

  localparam int INSTR_W = 32;
  localparam int IMM_W   = 25;
  localparam int ADDR_W  = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  typedef struct packed {
    logic [IMM_W-1:0]  imm;
    imm_src_t          imm_src;
    logic [ADDR_W-1:0] pc;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic              reg_we;
    logic              mem_we;
    logic              branch;
    logic              jump;
    logic              illegal;
  } dec_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational decoder: raw instruction + PC -> dec_t.
// Ports:
//   instr : 32-bit fetched instruction
//   pc    : PC of that instruction
//   dec   : decoded fields and control flags
// Unknown opcodes are flagged illegal with every enable cleared so the
// instruction can still travel downstream to the trap logic.
module opcode_decoder
  import decode_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  input  logic [ADDR_W-1:0]  pc,
  output dec_t               dec
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    dec          = '0;
    dec.imm      = instr[31:7];
    dec.imm_src  = IMM_I;
    dec.pc       = pc;
    dec.rd       = instr[11:7];
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.funct3   = instr[14:12];
    dec.funct7b5 = instr[30];

    unique case (instr[6:0])
      OP_LOAD, OP_IMM, OP_REG: dec.reg_we = 1'b1;
      OP_JALR: begin
        dec.reg_we = 1'b1;
        dec.jump   = 1'b1;
      end
      OP_STORE: begin
        dec.imm_src = IMM_S;
        dec.mem_we  = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm_src = IMM_B;
        dec.branch  = 1'b1;
      end
      OP_JAL: begin
        dec.imm_src = IMM_J;
        dec.reg_we  = 1'b1;
        dec.jump    = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage between fetch and the immediate extender / register file /
// execute control.
// Ports:
//   clk, arstn                      : clock, async active-low reset
//   i_flush                         : synchronous flush of both entries
//   i_instr_valid/o_instr_ready     : fetch-side handshake (ready registered)
//   i_instr, i_pc                   : fetched instruction and its PC
//   o_dec_valid/i_dec_ready         : downstream handshake
//   o_imm, o_imm_src, o_pc          : raw immediate field, type select, PC
//   o_rd, o_rs1, o_rs2, o_funct3,
//   o_funct7b5                      : register indices and function bits
//   o_reg_we, o_mem_we, o_branch,
//   o_jump, o_illegal               : decoded control flags
// A two-entry skid buffer (output register + skid register) keeps
// o_instr_ready registered, so i_dec_ready never reaches fetch
// combinationally while still sustaining one instruction per cycle.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int IMM_WIDTH   = 25,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   i_flush,
  input  logic                   i_instr_valid,
  output logic                   o_instr_ready,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  output logic                   o_dec_valid,
  input  logic                   i_dec_ready,
  output logic [IMM_WIDTH-1:0]   o_imm,
  output logic [1:0]             o_imm_src,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [4:0]             o_rd,
  output logic [4:0]             o_rs1,
  output logic [4:0]             o_rs2,
  output logic [2:0]             o_funct3,
  output logic                   o_funct7b5,
  output logic                   o_reg_we,
  output logic                   o_mem_we,
  output logic                   o_branch,
  output logic                   o_jump,
  output logic                   o_illegal
);

  dec_t dec_in;
  dec_t out_q, out_d;
  dec_t skid_q, skid_d;
  logic out_valid_q, out_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic ready_q;
  logic accept;

  opcode_decoder u_decoder (
    .instr (i_instr),
    .pc    (i_pc),
    .dec   (dec_in)
  );

  assign accept = i_instr_valid & ready_q;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;

    if (i_flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || i_dec_ready) begin
      // Output slot is free this cycle: the older skid entry goes first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = dec_in;
      end else if (accept) begin
        out_d       = dec_in;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the new instruction in the skid.
      skid_d       = dec_in;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      // NOTE: data registers are reset too so nothing from before reset can
      // reappear on the outputs; these are two small flop banks, not RAM.
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ~skid_valid_d;
    end
  end

  assign o_instr_ready = ready_q;
  assign o_dec_valid   = out_valid_q;
  assign o_imm         = out_q.imm;
  assign o_imm_src     = out_q.imm_src;
  assign o_pc          = out_q.pc;
  assign o_rd          = out_q.rd;
  assign o_rs1         = out_q.rs1;
  assign o_rs2         = out_q.rs2;
  assign o_funct3      = out_q.funct3;
  assign o_funct7b5    = out_q.funct7b5;
  assign o_reg_we      = out_q.reg_we;
  assign o_mem_we      = out_q.mem_we;
  assign o_branch      = out_q.branch;
  assign o_jump        = out_q.jump;
  assign o_illegal     = out_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage. Expected decodes are queued when
// an instruction is accepted and popped when the stage hands one downstream.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        arstn;
  logic        i_flush;
  logic        i_instr_valid;
  logic        o_instr_ready;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic        o_dec_valid;
  logic        i_dec_ready;
  logic [24:0] o_imm;
  logic [1:0]  o_imm_src;
  logic [31:0] o_pc;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic [2:0]  o_funct3;
  logic        o_funct7b5;
  logic        o_reg_we, o_mem_we, o_branch, o_jump, o_illegal;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  src;
    logic        reg_we, mem_we, branch, jump, illegal;
  } exp_t;

  exp_t sb[$];
  exp_t pending;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .clk           (clk),
    .arstn         (arstn),
    .i_flush       (i_flush),
    .i_instr_valid (i_instr_valid),
    .o_instr_ready (o_instr_ready),
    .i_instr       (i_instr),
    .i_pc          (i_pc),
    .o_dec_valid   (o_dec_valid),
    .i_dec_ready   (i_dec_ready),
    .o_imm         (o_imm),
    .o_imm_src     (o_imm_src),
    .o_pc          (o_pc),
    .o_rd          (o_rd),
    .o_rs1         (o_rs1),
    .o_rs2         (o_rs2),
    .o_funct3      (o_funct3),
    .o_funct7b5    (o_funct7b5),
    .o_reg_we      (o_reg_we),
    .o_mem_we      (o_mem_we),
    .o_branch      (o_branch),
    .o_jump        (o_jump),
    .o_illegal     (o_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an instruction with the decode the bench expects for it.
  task automatic offer(input logic [31:0] instr, input logic [31:0] pc, input logic [1:0] src,
                       input logic rw, input logic mw, input logic br, input logic jp,
                       input logic il);
    i_instr       = instr;
    i_pc          = pc;
    i_instr_valid = 1'b1;
    pending       = '{instr, pc, src, rw, mw, br, jp, il};
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_output", 32'(o_dec_valid), 32'd0);
      return;
    end
    e = sb.pop_front();
    check("imm",      32'(o_imm),      32'(e.instr[31:7]));
    check("imm_src",  32'(o_imm_src),  32'(e.src));
    check("pc",       o_pc,            e.pc);
    check("rd",       32'(o_rd),       32'(e.instr[11:7]));
    check("rs1",      32'(o_rs1),      32'(e.instr[19:15]));
    check("rs2",      32'(o_rs2),      32'(e.instr[24:20]));
    check("funct3",   32'(o_funct3),   32'(e.instr[14:12]));
    check("funct7b5", 32'(o_funct7b5), 32'(e.instr[30]));
    check("reg_we",   32'(o_reg_we),   32'(e.reg_we));
    check("mem_we",   32'(o_mem_we),   32'(e.mem_we));
    check("branch",   32'(o_branch),   32'(e.branch));
    check("jump",     32'(o_jump),     32'(e.jump));
    check("illegal",  32'(o_illegal),  32'(e.illegal));
  endtask

  // Called just after a falling edge with inputs set; evaluates the cycle's
  // handshakes against the scoreboard, then advances one clock.
  task automatic tick();
    exp_t h;
    #1;
    if (o_dec_valid && !i_dec_ready && sb.size() > 0) begin
      h = sb[0];
      check("hold_pc", o_pc, h.pc);
    end
    if (o_dec_valid && i_dec_ready && !i_flush) compare_front();
    if (i_instr_valid && o_instr_ready && !i_flush) sb.push_back(pending);
    if (i_flush) sb.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    i_instr_valid = 1'b0;
    i_flush       = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    i_dec_ready = 1'b1;
    while ((sb.size() > 0 || o_dec_valid) && n < 20) begin
      tick();
      n++;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    arstn = 1'b0; i_flush = 1'b0; i_instr_valid = 1'b0;
    i_instr = '0; i_pc = '0; i_dec_ready = 1'b0;
    pending = '{32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(o_dec_valid), 32'd0);
    check("rst_ready", 32'(o_instr_ready), 32'd1);
    check("rst_imm",   32'(o_imm), 32'd0);
    arstn = 1'b1;
    @(negedge clk);

    // lw x5,8(x2): one-cycle latency and known field values
    i_dec_ready = 1'b1;
    offer(32'h00812283, 32'h100, 2'b00, 1, 0, 0, 0, 0);
    tick();
    check("lw_latency", 32'(o_dec_valid), 32'd1);
    check("lw_imm_const", 32'(o_imm), 32'h10245);
    check("lw_rd_const", 32'(o_rd), 32'd5);
    idle();
    tick();

    // sw x6,12(x2)
    offer(32'h00612623, 32'h104, 2'b01, 0, 1, 0, 0, 0);
    tick();
    check("sw_rs2_const", 32'(o_rs2), 32'd6);
    idle();
    tick();

    // beq then jal back to back, no bubble
    offer(32'hFE000FE3, 32'h108, 2'b10, 0, 0, 1, 0, 0);
    tick();
    check("beq_valid", 32'(o_dec_valid), 32'd1);
    offer(32'h010000EF, 32'h10C, 2'b11, 1, 0, 0, 1, 0);
    tick();
    check("jal_no_bubble", 32'(o_dec_valid), 32'd1);
    check("jal_rd_const", 32'(o_rd), 32'd1);
    drain();

    // Backpressure: addi, add, jalr offered with downstream stalled
    i_dec_ready = 1'b0;
    offer(32'h00100093, 32'h200, 2'b00, 1, 0, 0, 0, 0);
    tick();
    offer(32'h002081B3, 32'h204, 2'b00, 1, 0, 0, 0, 0);
    tick();
    check("bp_ready_low", 32'(o_instr_ready), 32'd0);
    offer(32'h000080E7, 32'h208, 2'b00, 1, 0, 0, 1, 0);
    tick();
    tick();
    check("bp_held_pc", o_pc, 32'h200);
    check("bp_still_full", 32'(o_instr_ready), 32'd0);
    i_dec_ready = 1'b1;
    tick();
    tick();
    drain();

    // Flush with both entries full and a valid offered in the flush cycle
    i_dec_ready = 1'b0;
    offer(32'h00812283, 32'h300, 2'b00, 1, 0, 0, 0, 0);
    tick();
    offer(32'h00612623, 32'h304, 2'b01, 0, 1, 0, 0, 0);
    tick();
    check("fl_full_valid", 32'(o_dec_valid), 32'd1);
    check("fl_full_ready", 32'(o_instr_ready), 32'd0);
    offer(32'hFE000FE3, 32'h308, 2'b10, 0, 0, 1, 0, 0);
    i_flush = 1'b1;
    tick();
    idle();
    check("fl_valid", 32'(o_dec_valid), 32'd0);
    check("fl_ready", 32'(o_instr_ready), 32'd1);
    tick();
    check("fl_no_reappear", 32'(o_dec_valid), 32'd0);
    i_dec_ready = 1'b1;
    offer(32'h0000007F, 32'h30C, 2'b00, 0, 0, 0, 0, 1);
    tick();
    check("ill_flag", 32'(o_illegal), 32'd1);
    drain();

    // Asynchronous reset with both entries full
    i_dec_ready = 1'b0;
    offer(32'h00100093, 32'h400, 2'b00, 1, 0, 0, 0, 0);
    tick();
    offer(32'h002081B3, 32'h404, 2'b00, 1, 0, 0, 0, 0);
    tick();
    idle();
    check("ar_full_ready", 32'(o_instr_ready), 32'd0);
    #2 arstn = 1'b0;
    #1;
    check("ar_valid_now", 32'(o_dec_valid), 32'd0);
    check("ar_ready_now", 32'(o_instr_ready), 32'd1);
    check("ar_pc_now", o_pc, 32'd0);
    sb.delete();
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    check("ar_after_valid", 32'(o_dec_valid), 32'd0);
    i_dec_ready = 1'b1;
    offer(32'h010000EF, 32'h500, 2'b11, 1, 0, 0, 1, 0);
    tick();
    check("ar_resume", 32'(o_dec_valid), 32'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Decode stage between instruction fetch and the immediate extender / register file / execute control.
- Accepts a fetched instruction and its PC over a valid/ready handshake.
- Decodes the opcode into the 2-bit immediate-type select (00 I, 01 S, 10 B, 11 J), register indices and basic control flags. Presents instr[31:7] as the 25-bit immediate field, registered.
- Contains a 2-entry skid buffer, so o_instr_ready is a registered signal and fetch never sees a combinational path from i_dec_ready.

Parameters:
- INSTR_WIDTH, 32, instruction width. Only 32 is supported.
- IMM_WIDTH, 25, width of the raw immediate field passed downstream (instr[31:7]).
- ADDR_WIDTH, 32, PC width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- arstn  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous flush; discards all buffered instructions.
- i_instr_valid  in  1  fetch has an instruction.
- o_instr_ready  out  1  stage can accept an instruction; registered.
- i_instr  in  INSTR_WIDTH  fetched instruction.
- i_pc  in  ADDR_WIDTH  PC of i_instr.
- o_dec_valid  out  1  decoded outputs are valid.
- i_dec_ready  in  1  downstream consumes the decoded instruction.
- o_imm  out  IMM_WIDTH  instr[31:7], to the immediate extender.
- o_imm_src  out  2  immediate-type select, to the immediate extender.
- o_pc  out  ADDR_WIDTH  PC of the decoded instruction.
- o_rd, o_rs1, o_rs2  out  5 each  instr[11:7], instr[19:15], instr[24:20].
- o_funct3  out  3  instr[14:12].
- o_funct7b5  out  1  instr[30].
- o_reg_we, o_mem_we, o_branch, o_jump, o_illegal  out  1 each  decoded control flags.

Behaviour:
- Reset (arstn low, asynchronous):
  - Output and skid valid bits cleared; all data registers cleared to 0.
  - o_dec_valid=0; o_instr_ready=1.
  - Reset may assert mid-transfer. Any buffered instruction is lost; no partial state survives.
- Decode is combinational on the incoming instruction. Decoded fields are stored, not re-derived at the output.
- Latency: 1 cycle from accept (i_instr_valid & o_instr_ready) to o_dec_valid.
- Opcode map:
  - 0000011 load: src 00, reg_we=1.
  - 0010011 op-imm: src 00, reg_we=1.
  - 1100111 jalr: src 00, reg_we=1, jump=1.
  - 0110011 op: src 00, reg_we=1.
  - 0100011 store: src 01, mem_we=1.
  - 1100011 branch: src 10, branch=1.
  - 1101111 jal: src 11, reg_we=1, jump=1.
  - Any other opcode: illegal=1, src 00, reg_we=mem_we=branch=jump=0. The instruction still flows through so the trap logic sees it.
- Handshake:
  - An accept occurs only when i_instr_valid and o_instr_ready are both high.
  - A transfer occurs only when o_dec_valid and i_dec_ready are both high.
  - While o_dec_valid=1 and i_dec_ready=0, every output holds stable.
- Buffer update each cycle:
  - Output register empty, or transferring: load it from the skid if the skid is valid (skid then clears, or reloads from an accept in the same cycle). Otherwise load it from an accept. Otherwise clear it.
  - Output register full and stalled: an accept loads the skid.
- o_instr_ready next = NOT skid_valid_next. It deasserts the cycle after the skid fills.
- Ordering is strict FIFO. No instruction is dropped or duplicated.
- Flush:
  - Next cycle: both valid bits are 0 and o_instr_ready=1.
  - An accept in the flush cycle is discarded.
  - Flush has priority over accept and transfer.
- Simultaneous transfer and accept with the skid empty: the new instruction goes directly to the output register, with no bubble. Full throughput is 1 instruction per cycle.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams;
  - imm_src_t enum (IMM_I, IMM_S, IMM_B, IMM_J);
  - dec_t packed struct holding imm, imm_src, pc, rd, rs1, rs2, funct3, funct7b5 and the flags.
- Sub-module opcode_decoder is combinational, instr → dec_t. The stage instantiates it once on the input side.
- Output and skid registers are both of type dec_t.

Test Plan:
- Reset, then accept 0x00812283 (lw x5,8(x2)) → 1 cycle later o_dec_valid=1, o_imm=0x10245, o_imm_src=00, rd=5, rs1=2, reg_we=1, mem_we=0.
- Accept 0x00612623 (sw x6,12(x2)) → o_imm_src=01, mem_we=1, reg_we=0, rs2=6.
- Accept 0xFE000FE3 (beq x0,x0,-4) then 0x010000EF (jal x1,16) back to back with i_dec_ready=1:
  - first → src=10, branch=1;
  - second → src=11, jump=1, rd=1;
  - o_dec_valid stays high on consecutive cycles with no bubble.
- Backpressure:
  - Hold i_dec_ready=0 and offer 3 instructions back to back → first is held at the output, second fills the skid, o_instr_ready=0 from the next cycle, third is not accepted.
  - Release i_dec_ready → outputs in order 1, 2, 3 with no loss or duplication.
- With both entries full, pulse i_flush together with i_instr_valid=1 → next cycle o_dec_valid=0, o_instr_ready=1, and the flushed instructions never appear. Then 0x0000007F → o_illegal=1, all enables 0.
- Assert arstn low while o_dec_valid=1 and the skid is full → o_dec_valid=0 and o_instr_ready=1 immediately, without waiting for a clock edge. After release, normal operation resumes.
